// File: rtl/river_ride_ctrl.sv
// River ride controller: merges lilypad collisions/motion into a per-frame carry delta and runs the
// LAND/RIDE/GRACE/SINK drowning FSM. Optional `RIVER_EDGE_KILL_EN turns screen-edge events into drowning.
module river_ride_ctrl #(
  parameter int NUM_PADS     = 4,
  parameter int RIVER_Y_MIN  = 40,
  parameter int RIVER_Y_MAX  = 240,
  parameter int GRACE_FRAMES = 2,
  parameter int SINK_FRAMES  = 8,
  parameter int SCREEN_X_MAX = 640,
  parameter int FROG_SIDE    = 40
) (
  input  logic                          frame_clk,
  input  logic                          Reset,
  input  logic [10:0]                   Frog_X,
  input  logic [10:0]                   Frog_Y,
  input  logic                          Frog_Hop,
  input  logic [NUM_PADS-1:0]           Pad_Collision,
  input  logic [11*NUM_PADS-1:0]        Pad_MotionX,
  output logic [10:0]                   Carry_X,
  output logic [$clog2(NUM_PADS)-1:0]   Ride_Pad_Idx,
  output logic [1:0]                    Ride_State,
  output logic                          Frog_Drown,
  output logic                          Frog_Respawn
);
  localparam int IDX_W = $clog2(NUM_PADS);
  localparam int GW    = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;
  localparam int SW    = (SINK_FRAMES > 1) ? $clog2(SINK_FRAMES) : 1;

  typedef enum logic [1:0] {LAND = 2'd0, RIDE = 2'd1, GRACE = 2'd2, SINK = 2'd3} state_t;

  state_t              state, state_nx;
  logic [10:0]         carry_nx;
  logic [IDX_W-1:0]    idx_nx;
  logic [GW-1:0]       grace_cnt, grace_nx;
  logic [SW-1:0]       sink_cnt, sink_nx;
  logic                drown_nx, resp_nx;

  logic [NUM_PADS-1:0][10:0] motion;
  logic                in_river, hit;
  logic [IDX_W-1:0]    sel, ride_idx;
  logic [10:0]         m, m_mag, clamp;
  logic                m_neg, edge_l, edge_r, edge_evt, go_ride;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_mot
    assign motion[g] = Pad_MotionX[11*g +: 11];
  end

  assign in_river = (Frog_Y >= 11'(RIVER_Y_MIN)) && (Frog_Y < 11'(RIVER_Y_MAX));
  assign hit      = |Pad_Collision;

  // lowest set index wins on overlapping pads
  always_comb begin
    sel = '0;
    for (int i = NUM_PADS - 1; i >= 0; i--)
      if (Pad_Collision[i]) sel = IDX_W'(i);
  end

  // keep the latched pad while it still collides, otherwise fall back to sel
  assign ride_idx = (state == RIDE && Pad_Collision[Ride_Pad_Idx]) ? Ride_Pad_Idx : sel;
  assign m        = motion[ride_idx];
  assign m_neg    = m[10];
  assign m_mag    = m_neg ? (11'd0 - m) : m;
  assign edge_l   = m_neg && (Frog_X < m_mag);
  assign edge_r   = !m_neg &&
                    (({2'b00, Frog_X} + 13'(FROG_SIDE) + {2'b00, m}) > 13'(SCREEN_X_MAX));
  assign edge_evt = edge_l || edge_r;
  assign clamp    = edge_l ? (11'd0 - Frog_X) :
                    edge_r ? (11'(SCREEN_X_MAX - FROG_SIDE) - Frog_X) : m;

  always_comb begin
    state_nx = state;
    carry_nx = '0;
    idx_nx   = Ride_Pad_Idx;
    grace_nx = grace_cnt;
    sink_nx  = sink_cnt;
    drown_nx = 1'b0;
    resp_nx  = 1'b0;
    go_ride  = 1'b0;
    case (state)
      LAND: begin
        if (in_river) begin
          if (hit) go_ride = 1'b1;
          else begin
            state_nx = GRACE;
            grace_nx = '0;
          end
        end
      end
      RIDE: begin
        if (!in_river) state_nx = LAND;
        else if (!hit) begin
          state_nx = GRACE;
          grace_nx = '0;
        end else go_ride = 1'b1;
      end
      GRACE: begin
        if (!in_river) state_nx = LAND;
        else if (hit) go_ride = 1'b1;
        else if (!Frog_Hop) begin
          // a hop freezes the grace timer, so the sink decision waits too
          if (grace_cnt == GW'(GRACE_FRAMES - 1)) begin
            state_nx = SINK;
            drown_nx = 1'b1;
            sink_nx  = '0;
          end else grace_nx = grace_cnt + 1'b1;
        end
      end
      SINK: begin
        if (sink_cnt == SW'(SINK_FRAMES - 1)) begin
          state_nx = LAND;
          resp_nx  = 1'b1;
          sink_nx  = '0;
        end else sink_nx = sink_cnt + 1'b1;
      end
      default: state_nx = LAND;
    endcase

    if (go_ride) begin
      idx_nx = ride_idx;
`ifdef RIVER_EDGE_KILL_EN
      if (edge_evt) begin
        state_nx = SINK;
        drown_nx = 1'b1;
        sink_nx  = '0;
      end else begin
        state_nx = RIDE;
        carry_nx = m;
      end
`else
      state_nx = RIDE;
      carry_nx = edge_evt ? clamp : m;
`endif
    end

    if (Frog_Hop) carry_nx = '0;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state        <= LAND;
      Carry_X      <= '0;
      Ride_Pad_Idx <= '0;
      grace_cnt    <= '0;
      sink_cnt     <= '0;
      Frog_Drown   <= 1'b0;
      Frog_Respawn <= 1'b0;
    end else begin
      state        <= state_nx;
      Carry_X      <= carry_nx;
      Ride_Pad_Idx <= idx_nx;
      grace_cnt    <= grace_nx;
      sink_cnt     <= sink_nx;
      Frog_Drown   <= drown_nx;
      Frog_Respawn <= resp_nx;
    end
  end

  assign Ride_State = state;
endmodule
